switch_input_conditioner: RTL and testbench
===========================================

// Module: switch_input_conditioner
// PURPOSE
// Conditions raw board inputs (16 switches + 1 confirm button) before the data memory's switch
// read path consumes them. Synchronises and debounces every input, then captures a stable
// switch snapshot on each confirm-button press, holding it with a valid flag until the CPU
// acknowledges the read. Output io_rdata_switch drives the data memory's io_rdata_switch input.
// PARAMETERS
// WIDTH     16         number of switch inputs
// DB_TICK   1_000_000  clk cycles per debounce sample tick (10 ms @ 100 MHz); benches use 4
// CNT_W     20         tick counter width; must satisfy 2**CNT_W >= DB_TICK
// PORTS
// clk              in   1      system clock, all state on posedge
// rst              in   1      asynchronous, active-high reset
// sw_raw           in   WIDTH  raw switch pins, asynchronous to clk
// btn_raw          in   1      raw confirm button pin, asynchronous, 1 = pressed
// rd_ack           in   1      one-cycle pulse: CPU has read the captured value (decoded by caller)
// io_rdata_switch  out  WIDTH  captured switch snapshot, to data memory switch input
// sw_live          out  WIDTH  debounced live switch value (not captured)
// data_valid       out  1      snapshot captured and not yet acknowledged
// overrun          out  1      sticky: snapshot overwritten before acknowledge
// BEHAVIOUR
// - Reset: every flop 0 -> io_rdata_switch=0, sw_live=0, data_valid=0, overrun=0, FSM=IDLE,
//   tick counter=0, sync/sample regs=0. Asserting rst mid-operation clears all immediately.
// - Sync: each of WIDTH+1 inputs passes a 2-flop synchroniser; sync value = 2nd flop.
// - Tick: counter runs 0..DB_TICK-1 and wraps; tick=1 for one cycle when counter==DB_TICK-1.
// - Debounce (per bit): on tick edge, shreg <= {shreg[1:0], sync}; if {shreg[1:0],sync}==3'b111
//   db<=1, ==3'b000 db<=0, else db holds. db updates on the same edge as the tick.
//   Latency raw->db: 2 sync cycles + 3 ticks (max 2+3*DB_TICK+1 cycles). Pulses shorter than
//   one tick period never change db. sw_live = switch db bits.
// - Button edge: btn_prev <= btn_db each cycle; press = btn_db & ~btn_prev (one cycle).
// - Capture FSM (2 states, registered):
//   IDLE: press -> io_rdata_switch<=sw_live (value before same-edge update), data_valid<=1,
//         go FULL. rd_ack in IDLE ignored.
//   FULL: rd_ack & ~press -> data_valid<=0, overrun<=0, go IDLE; io_rdata_switch holds.
//         press & ~rd_ack  -> recapture, overrun<=1, stay FULL.
//         press & rd_ack   -> recapture, data_valid stays 1, overrun<=0, stay FULL.
// - io_rdata_switch changes only on capture or reset; it holds across ack.
// - Holding button down produces exactly one press; release produces none.
// STRUCTURE
// - Shared package: state encoding (ST_IDLE=1'b0, ST_FULL=1'b1), default DB_TICK constant.
// - Sub-module debounce_bit: 2-flop sync + 3-bit shreg + db flop, ports clk, rst, tick, raw,
//   db; instantiated WIDTH+1 times via generate. Tick counter and capture FSM in top.
// TESTING (DB_TICK=4)
// 1 rst pulse with sw_raw=FFFF, btn_raw=1 -> all outputs 0 during and right after rst.
// 2 sw_raw=16'hA5C3 held -> sw_live=A5C3 within 15 cycles, not before 3rd tick post-sync.
// 3 sw_raw[0] high for 3 cycles between ticks then low -> sw_live[0] stays 0.
// 4 sw=1234, press btn -> io_rdata_switch=1234, data_valid=1; rd_ack -> valid=0, value=1234.
// 5 press (sw=1111), press again (sw=2222) no ack -> io_rdata_switch=2222, overrun=1;
//   then rd_ack coincident with press (sw=3333) -> value=3333, valid=1, overrun=0.
// 6 rst asserted mid-debounce with button held -> outputs 0 asynchronously; after release of
//   rst with button still held, one press after debounce latency.

Source files
------------

// File: rtl/switch_input_conditioner_pkg.sv
// Purpose : shared types and constants for the switch input conditioner.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Holds the capture FSM state encoding, the default debounce timing and the
// debounce window geometry used by both the per-bit debouncer and the top.
package switch_input_conditioner_pkg;

    // Capture FSM states. The encoding is fixed so the single state flop reads
    // directly as "a snapshot is being held".
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } cap_state_t;

    // 10 ms sample period at a 100 MHz core clock.
    localparam int DB_TICK_DEFAULT = 1_000_000;

    // Tick counter width; 2**20 covers the default tick period.
    localparam int CNT_W_DEFAULT   = 20;

    // A debounced bit changes only after this many consecutive equal samples.
    localparam int DB_WIN          = 3;

    // Samples that must be remembered between ticks: the window minus the
    // sample being taken right now.
    localparam int DB_HIST         = DB_WIN - 1;

endpackage : switch_input_conditioner_pkg

// File: rtl/switch_input_conditioner_debounce_bit.sv
// Purpose : synchronise and debounce one raw, asynchronous input pin.
// Latency : 2 cycles of sync, then 3 sample ticks of a steady level before db moves.
// Backpressure: none; free-running, sampled only when tick is high.
//
// Ports
//   clk   in  core clock, all state on posedge
//   rst   in  asynchronous active-high reset, clears every flop
//   tick  in  one-cycle sample strobe from the shared tick counter
//   raw   in  raw pin, asynchronous to clk
//   db    out debounced level (registered)
module switch_input_conditioner_debounce_bit
    import switch_input_conditioner_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic db
);

    // Two-flop synchroniser; only sync2_q is used downstream.
    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;

    // Previous tick samples. Together with the current synchronised value
    // they form the 3-sample window {older, old, now}.
    logic [DB_HIST-1:0] hist_q;
    logic [DB_HIST-1:0] hist_d;

    logic db_q;
    logic db_d;

    logic [DB_WIN-1:0] win;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        win     = {hist_q, sync2_q};
        hist_d  = hist_q;
        db_d    = db_q;

        if (tick) begin
            // Shift the current sample in; the oldest one drops out.
            hist_d = win[DB_HIST-1:0];
            // Only a full window of agreement moves the output; any mix holds,
            // so a glitch shorter than one tick period can never flip db.
            if (&win) begin
                db_d = 1'b1;
            end else if (~|win) begin
                db_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            db_q    <= db_d;
        end
    end

    assign db = db_q;

endmodule : switch_input_conditioner_debounce_bit

// File: rtl/switch_input_conditioner.sv
// Purpose : debounce 16 switches + confirm button; latch a switch snapshot per press.
// Latency : raw->sw_live 2 cycles + 3 ticks; press->snapshot 1 cycle after button db rises.
// Backpressure: none; an unacknowledged snapshot is overwritten and flagged via overrun.
//
// Ports
//   clk              in   core clock, all state on posedge
//   rst              in   asynchronous active-high reset
//   sw_raw           in   WIDTH raw switch pins, asynchronous
//   btn_raw          in   raw confirm button, 1 = pressed, asynchronous
//   rd_ack           in   one-cycle pulse: CPU has consumed the snapshot
//   io_rdata_switch  out  WIDTH captured snapshot, feeds the data memory switch read port
//   sw_live          out  WIDTH debounced live switch value
//   data_valid       out  snapshot held and not yet acknowledged
//   overrun          out  sticky: a snapshot was replaced before being acknowledged
module switch_input_conditioner
    import switch_input_conditioner_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DB_TICK = DB_TICK_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             btn_raw,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] io_rdata_switch,
    output logic [WIDTH-1:0] sw_live,
    output logic             data_valid,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DB_TICK - 1);

    // ------------------------------------------------------------------
    // Shared sample tick: counter runs 0..DB_TICK-1, tick on the last count.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    always_comb begin
        tick  = (cnt_q == TICK_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // ------------------------------------------------------------------
    // Per-pin debouncers. The button rides in the top bit so all WIDTH+1
    // inputs share one generate loop and one tick.
    // ------------------------------------------------------------------
    logic [WIDTH:0] raw_all;
    logic [WIDTH:0] db_all;

    assign raw_all = {btn_raw, sw_raw};

    for (genvar i = 0; i < WIDTH + 1; i++) begin : g_db
        switch_input_conditioner_debounce_bit u_db (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .raw  (raw_all[i]),
            .db   (db_all[i])
        );
    end

    logic btn_db;
    assign btn_db  = db_all[WIDTH];
    assign sw_live = db_all[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Press detect: rising edge of the debounced button. A held button
    // produces a single press; release produces none.
    // ------------------------------------------------------------------
    logic btn_prev_q;
    logic btn_prev_d;
    logic press;

    always_comb begin
        btn_prev_d = btn_db;
        press      = btn_db & ~btn_prev_q;
    end

    // ------------------------------------------------------------------
    // Capture FSM. All outputs are flops so the data memory sees clean,
    // glitch-free values.
    // ------------------------------------------------------------------
    cap_state_t       state_q;
    cap_state_t       state_d;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                // rd_ack with nothing held is meaningless and ignored.
                if (press) begin
                    // sw_live is the value before this edge's debounce update.
                    rdata_d = sw_live;
                    valid_d = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (press && rd_ack) begin
                    // Old snapshot consumed and a new one taken on the same
                    // edge: nothing was lost, so overrun clears.
                    rdata_d   = sw_live;
                    valid_d   = 1'b1;
                    overrun_d = 1'b0;
                end else if (press) begin
                    rdata_d   = sw_live;
                    overrun_d = 1'b1;
                end else if (rd_ack) begin
                    // Snapshot value stays visible after the ack.
                    valid_d   = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            btn_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_prev_d;
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign io_rdata_switch = rdata_q;
    assign data_valid      = valid_q;
    assign overrun         = overrun_q;

endmodule : switch_input_conditioner

// File: tb/tb_switch_input_conditioner.sv
// Purpose : directed self-checking bench for switch_input_conditioner (DB_TICK = 4).
// Latency : n/a.
// Backpressure: n/a.
module tb_switch_input_conditioner;

    localparam int WIDTH   = 16;
    localparam int DB_TICK = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic             btn_raw;
    logic             rd_ack;
    logic [WIDTH-1:0] io_rdata_switch;
    logic [WIDTH-1:0] sw_live;
    logic             data_valid;
    logic             overrun;

    int n_checks;
    int n_fail;

    // Edges since reset release: edge k samples tick counter value (k-1)%4,
    // so debounce samples land on edges where edge_n % 4 == 0.
    int unsigned edge_n;

    switch_input_conditioner #(
        .WIDTH   (WIDTH),
        .DB_TICK (DB_TICK),
        .CNT_W   (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sw_raw          (sw_raw),
        .btn_raw         (btn_raw),
        .rd_ack          (rd_ack),
        .io_rdata_switch (io_rdata_switch),
        .sw_live         (sw_live),
        .data_valid      (data_valid),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one posedge and settle 1 time unit past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Move to just after an edge where a debounce sample was taken.
    task automatic align_tick();
        while (edge_n % DB_TICK != 0) cycle();
    endtask

    // Full press: hold long enough to debounce and capture, then release
    // long enough for the button to debounce back to 0.
    task automatic press_btn();
        btn_raw = 1'b1;
        cycles(20);
        btn_raw = 1'b0;
        cycles(20);
    endtask

    task automatic check_outs(input string tag, input logic [15:0] rdata, input logic [15:0] live,
                              input logic vld, input logic ovr);
        check_eq({tag, "_rdata"},   32'(io_rdata_switch), 32'(rdata));
        check_eq({tag, "_live"},    32'(sw_live),         32'(live));
        check_eq({tag, "_valid"},   32'(data_valid),      32'(vld));
        check_eq({tag, "_overrun"}, 32'(overrun),         32'(ovr));
    endtask

    initial begin
        logic glitch_seen;
        n_checks = 0;
        n_fail   = 0;

        // 1: reset with all inputs high.
        rst     = 1'b1;
        sw_raw  = 16'hFFFF;
        btn_raw = 1'b1;
        rd_ack  = 1'b0;
        cycles(3);
        check_outs("rst_during", 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        cycle();
        check_outs("rst_after", 16'h0000, 16'h0000, 1'b0, 1'b0);
        sw_raw  = 16'h0000;
        btn_raw = 1'b0;
        cycles(24);
        check_outs("idle_quiet", 16'h0000, 16'h0000, 1'b0, 1'b0);

        // 2: steady pattern, exact latency: change after sample edge a,
        // sync valid after a+2, samples at a+4, a+8, a+12.
        align_tick();
        sw_raw = 16'hA5C3;
        cycles(11);
        check_eq("lat_not_early", 32'(sw_live), 32'h0000);
        cycle();
        check_eq("lat_on_time", 32'(sw_live), 32'hA5C3);
        check_eq("lat_no_capture", 32'(data_valid), 32'h0);

        // 3: short pulse on bit 0 must be filtered.
        sw_raw = 16'hA5C2;
        cycles(20);
        check_eq("bit0_low", 32'(sw_live), 32'hA5C2);
        align_tick();
        sw_raw[0] = 1'b1;
        cycles(3);
        sw_raw[0] = 1'b0;
        glitch_seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (sw_live[0]) glitch_seen = 1'b1;
        end
        check_eq("glitch_filtered", 32'(glitch_seen), 32'h0);
        check_eq("glitch_live", 32'(sw_live), 32'hA5C2);

        // 4: capture, hold button while switches move, then ack.
        sw_raw = 16'h1234;
        cycles(20);
        btn_raw = 1'b1;
        cycles(20);
        check_outs("cap1", 16'h1234, 16'h1234, 1'b1, 1'b0);
        sw_raw = 16'h4321;
        cycles(20);
        check_outs("hold_one_press", 16'h1234, 16'h4321, 1'b1, 1'b0);
        btn_raw = 1'b0;
        cycles(20);
        check_outs("release_no_press", 16'h1234, 16'h4321, 1'b1, 1'b0);
        rd_ack = 1'b1;
        cycle();
        rd_ack = 1'b0;
        check_outs("ack1", 16'h1234, 16'h4321, 1'b0, 1'b0);
        rd_ack = 1'b1;
        cycle();
        rd_ack = 1'b0;
        check_outs("ack_idle_ignored", 16'h1234, 16'h4321, 1'b0, 1'b0);

        // 5: overrun, then ack coincident with a new press.
        sw_raw = 16'h1111;
        cycles(20);
        press_btn();
        check_outs("cap_1111", 16'h1111, 16'h1111, 1'b1, 1'b0);
        sw_raw = 16'h2222;
        cycles(20);
        press_btn();
        check_outs("overrun_2222", 16'h2222, 16'h2222, 1'b1, 1'b1);
        sw_raw = 16'h3333;
        cycles(20);
        // Button set after sample edge a: db rises after a+12, capture at a+13.
        align_tick();
        btn_raw = 1'b1;
        cycles(12);
        check_outs("pre_coincident", 16'h2222, 16'h3333, 1'b1, 1'b1);
        rd_ack = 1'b1;
        cycle();
        rd_ack = 1'b0;
        check_outs("coincident", 16'h3333, 16'h3333, 1'b1, 1'b0);
        btn_raw = 1'b0;
        cycles(24);

        // 6: asynchronous reset mid-debounce with the button held.
        sw_raw  = 16'hFFFF;
        btn_raw = 1'b1;
        cycles(6);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(11);
        check_outs("post_rst_e11", 16'h0000, 16'h0000, 1'b0, 1'b0);
        cycle();
        check_outs("post_rst_e12", 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        cycle();
        check_outs("post_rst_press", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        cycles(30);
        check_outs("post_rst_single", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_switch_input_conditioner
